fcn_feeder: RTL and testbench

Host-side front end for the `fcn` inference block. It accepts a byte stream over a valid/ready handshake and unpacks typed packets (input vector, fc1 weight matrix, fc2 weight vector) into staging arrays. It issues the one-cycle whole-array write pulses and the `start` pulse that `fcn` consumes, waits for `done`, and returns `fc2_logit` to the host on a valid/ready result channel.

---
 rtl/fcn_feeder.sv | 189 ++++++++++++++++++
 tb/tb_fcn_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcn_feeder.sv
// Host byte-stream front end for fcn: unpacks typed packets into staging arrays, pulses writes/start, returns the logit.
// Latency: write pulse the cycle after the last byte, start one cycle later, r_valid the cycle after done.
// Backpressure: s_ready drops from COMMIT through RESULT; r_valid holds until r_ready. FCN_FEEDER_TIMEOUT_EN adds a WAIT watchdog.
module fcn_feeder #(
    parameter int IN1_N       = 132,
    parameter int OUT1_M      = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [7:0]                   s_data,
    input  logic [1:0]                   s_kind,
    input  logic                         s_last,
    output logic                         in_vec_wr,
    output logic [8*IN1_N-1:0]           in_vec_array,
    output logic                         fc1_w_wr_all,
    output logic [8*OUT1_M*IN1_N-1:0]    fc1_w_array,
    output logic                         fc2_w_wr_all,
    output logic [8*OUT1_M-1:0]          fc2_w_array,
    output logic                         start,
    input  logic                         done,
    input  logic [23:0]                  fc2_logit,
    output logic                         r_valid,
    input  logic                         r_ready,
    output logic [23:0]                  r_logit,
    output logic                         err,
    output logic                         busy
);

    localparam int FC1_LEN = OUT1_M * IN1_N;
    localparam int CW      = $clog2(FC1_LEN + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DRAIN  = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;

    function automatic logic [CW-1:0] pkt_len(input logic [1:0] k);
        case (k)
            2'b00:   pkt_len = CW'(IN1_N);
            2'b01:   pkt_len = CW'(FC1_LEN);
            2'b10:   pkt_len = CW'(OUT1_M);
            default: pkt_len = '0;
        endcase
    endfunction

    logic [2:0]                state_q, state_d;
    logic [1:0]                kind_q, kind_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [23:0]               r_logit_q, r_logit_d;
    logic [8*IN1_N-1:0]        in_vec_q, in_vec_d;
    logic [8*FC1_LEN-1:0]      fc1_q, fc1_d;
    logic [8*OUT1_M-1:0]       fc2_q, fc2_d;
`ifdef FCN_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]             tmo_q, tmo_d;
`endif

    logic          accept;
    logic          loading;
    logic [1:0]    cur_kind;
    logic [CW-1:0] cur_len;
    logic [CW-1:0] wr_idx;
    logic          at_end;

    assign accept   = s_valid & s_ready;
    assign loading  = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign cur_kind = (state_q == S_IDLE) ? s_kind : kind_q;
    assign cur_len  = pkt_len(cur_kind);
    assign wr_idx   = (state_q == S_IDLE) ? '0 : cnt_q;
    // Reserved kind has length 0, so the wrapped compare never matches.
    assign at_end   = (wr_idx == cur_len - 1'b1);

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        r_logit_d = r_logit_q;
        in_vec_d  = in_vec_q;
        fc1_d     = fc1_q;
        fc2_d     = fc2_q;
`ifdef FCN_FEEDER_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        if (accept && loading && (cur_kind != 2'b11) && (wr_idx < cur_len)) begin
            case (cur_kind)
                2'b00:   in_vec_d[{wr_idx, 3'b000} +: 8] = s_data;
                2'b01:   fc1_d[{wr_idx, 3'b000} +: 8]    = s_data;
                default: fc2_d[{wr_idx, 3'b000} +: 8]    = s_data;
            endcase
        end
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    kind_d = cur_kind;
                    cnt_d  = wr_idx + 1'b1;
                    if (cur_kind == 2'b11) begin
                        if (s_last) err_d = 1'b1;
                        state_d = s_last ? S_IDLE : S_DRAIN;
                    end else if (s_last) begin
                        err_d   = ~at_end;
                        state_d = at_end ? S_COMMIT : S_IDLE;
                    end else begin
                        state_d = at_end ? S_DRAIN : S_LOAD;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && s_last) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_COMMIT: state_d = (kind_q == 2'b00) ? S_RUN : S_IDLE;
            S_RUN: begin
                state_d = S_WAIT;
`ifdef FCN_FEEDER_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (done) begin
                    r_logit_d = fc2_logit;
                    state_d   = S_RESULT;
                end
`ifdef FCN_FEEDER_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_RESULT: if (r_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            r_logit_q <= '0;
            in_vec_q  <= '0;
            fc1_q     <= '0;
            fc2_q     <= '0;
`ifdef FCN_FEEDER_TIMEOUT_EN
            tmo_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            r_logit_q <= r_logit_d;
            in_vec_q  <= in_vec_d;
            fc1_q     <= fc1_d;
            fc2_q     <= fc2_d;
`ifdef FCN_FEEDER_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Gated by rst so the host sees no ready while reset is held.
    assign s_ready      = ~rst & ((state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DRAIN));
    assign busy         = (state_q != S_IDLE);
    assign in_vec_wr    = (state_q == S_COMMIT) && (kind_q == 2'b00);
    assign fc1_w_wr_all = (state_q == S_COMMIT) && (kind_q == 2'b01);
    assign fc2_w_wr_all = (state_q == S_COMMIT) && (kind_q == 2'b10);
    assign start        = (state_q == S_RUN);
    assign r_valid      = (state_q == S_RESULT);
    assign r_logit      = r_logit_q;
    assign err          = err_q;
    assign in_vec_array = in_vec_q;
    assign fc1_w_array  = fc1_q;
    assign fc2_w_array  = fc2_q;

endmodule

// File: tb/tb_fcn_feeder.sv
// Directed-random bench for fcn_feeder with a packet-level reference model of the staging arrays and pulses.
module tb_fcn_feeder;
    localparam int N  = 4;
    localparam int M  = 2;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid, s_ready, s_last;
    logic [7:0]      s_data;
    logic [1:0]      s_kind;
    logic            in_vec_wr, fc1_w_wr_all, fc2_w_wr_all, start, done;
    logic [8*N-1:0]  in_vec_array;
    logic [8*M*N-1:0] fc1_w_array;
    logic [8*M-1:0]  fc2_w_array;
    logic [23:0]     fc2_logit, r_logit;
    logic            r_valid, r_ready, err, busy;

    fcn_feeder #(.IN1_N(N), .OUT1_M(M), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_kind(s_kind), .s_last(s_last), .in_vec_wr(in_vec_wr), .in_vec_array(in_vec_array),
        .fc1_w_wr_all(fc1_w_wr_all), .fc1_w_array(fc1_w_array), .fc2_w_wr_all(fc2_w_wr_all),
        .fc2_w_array(fc2_w_array), .start(start), .done(done), .fc2_logit(fc2_logit),
        .r_valid(r_valid), .r_ready(r_ready), .r_logit(r_logit), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts and last-seen cycle of every strobe.
    int n_inwr = 0, n_fc1 = 0, n_fc2 = 0, n_start = 0, n_err = 0, n_rv = 0;
    int t_inwr = -1, t_fc1 = -1, t_fc2 = -1, t_start = -1, t_err = -1;
    always @(negedge clk) begin
        if (in_vec_wr)    begin n_inwr++;  t_inwr  = cyc; end
        if (fc1_w_wr_all) begin n_fc1++;   t_fc1   = cyc; end
        if (fc2_w_wr_all) begin n_fc2++;   t_fc2   = cyc; end
        if (start)        begin n_start++; t_start = cyc; end
        if (err)          begin n_err++;   t_err   = cyc; end
        if (r_valid)      n_rv++;
    end

    int n_cmp = 0, n_fail = 0;
    int t_last;
    logic [7:0] pkt [0:15];
    logic [7:0] m_in [0:N-1];
    logic [7:0] m_fc1 [0:M*N-1];
    logic [7:0] m_fc2 [0:M-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic int model_len(input logic [1:0] k);
        case (k)
            2'b00:   return N;
            2'b01:   return M * N;
            2'b10:   return M;
            default: return 0;
        endcase
    endfunction

    task automatic check_stage(input string tag);
        logic [63:0] e_in, e_f1, e_f2;
        e_in = '0; e_f1 = '0; e_f2 = '0;
        for (int k = 0; k < N; k++)     e_in[k*8 +: 8] = m_in[k];
        for (int k = 0; k < M * N; k++) e_f1[k*8 +: 8] = m_fc1[k];
        for (int k = 0; k < M; k++)     e_f2[k*8 +: 8] = m_fc2[k];
        check({tag, "_in_vec"}, 64'(in_vec_array), e_in);
        check({tag, "_fc1"},    64'(fc1_w_array),  e_f1);
        check({tag, "_fc2"},    64'(fc2_w_array),  e_f2);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
    endtask

    task automatic send_pkt(input logic [1:0] kind, input int n, input bit with_last);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = pkt[i];
            s_kind  = (i == 0) ? kind : 2'($urandom_range(0, 3));
            s_last  = with_last && (i == n - 1);
            @(negedge clk);
            for (int w = 0; w < 20 && !s_ready; w++) @(negedge clk);
            if (!s_ready) check("s_ready_during_load", {63'b0, s_ready}, 64'd1);
            @(posedge clk); #1;
        end
        t_last  = cyc;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_pkt(input logic [1:0] kind, input int n);
        int len, c_in, c_f1, c_f2, c_st, c_er;
        bit ok;
        string tg;
        tg  = $sformatf("k%0d_n%0d", kind, n);
        len = model_len(kind);
        ok  = (kind != 2'b11) && (n == len);
        for (int i = 0; i < n && i < len; i++) begin
            case (kind)
                2'b00:   m_in[i]  = pkt[i];
                2'b01:   m_fc1[i] = pkt[i];
                default: m_fc2[i] = pkt[i];
            endcase
        end
        c_in = n_inwr; c_f1 = n_fc1; c_f2 = n_fc2; c_st = n_start; c_er = n_err;
        send_pkt(kind, n, 1'b1);
        repeat (3) @(negedge clk);
        check({tg, "_s_ready"}, {63'b0, s_ready}, {63'b0, !(ok && kind == 2'b00)});
        check({tg, "_in_wr_cnt"},  n_inwr - c_in,  (ok && kind == 2'b00) ? 1 : 0);
        check({tg, "_fc1_wr_cnt"}, n_fc1 - c_f1,   (ok && kind == 2'b01) ? 1 : 0);
        check({tg, "_fc2_wr_cnt"}, n_fc2 - c_f2,   (ok && kind == 2'b10) ? 1 : 0);
        check({tg, "_start_cnt"},  n_start - c_st, (ok && kind == 2'b00) ? 1 : 0);
        check({tg, "_err_cnt"},    n_err - c_er,   ok ? 0 : 1);
        if (!ok) check({tg, "_err_time"}, t_err, t_last);
        if (ok && kind == 2'b00) begin
            check({tg, "_in_wr_time"}, t_inwr, t_last);
            check({tg, "_start_time"}, t_start, t_last + 1);
        end
        if (ok && kind == 2'b01) check({tg, "_fc1_wr_time"}, t_fc1, t_last);
        if (ok && kind == 2'b10) check({tg, "_fc2_wr_time"}, t_fc2, t_last);
        check_stage(tg);
    endtask

    task automatic do_infer(input int delay, input logic [23:0] logit);
        check("wait_busy",    {63'b0, busy},    64'd1);
        check("wait_s_ready", {63'b0, s_ready}, 64'd0);
        check("wait_r_valid", {63'b0, r_valid}, 64'd0);
        repeat (delay) @(posedge clk);
        #1 done = 1'b1; fc2_logit = logit;
        @(posedge clk); #1 done = 1'b0; fc2_logit = 24'($urandom);
        @(negedge clk);
        check("res_r_valid", {63'b0, r_valid}, 64'd1);
        check("res_r_logit", 64'(r_logit), 64'(logit));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_r_valid", i), {63'b0, r_valid}, 64'd1);
            check($sformatf("hold%0d_r_logit", i), 64'(r_logit), 64'(logit));
            check($sformatf("hold%0d_s_ready", i), {63'b0, s_ready}, 64'd0);
        end
        r_ready = 1'b1;
        @(posedge clk); #1 r_ready = 1'b0;
        @(negedge clk);
        check("post_res_r_valid", {63'b0, r_valid}, 64'd0);
        check("post_res_s_ready", {63'b0, s_ready}, 64'd1);
        check("post_res_busy",    {63'b0, busy},    64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] logit2;
        int c_rv, c_er, kind_r, n_r;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_kind = '0; s_last = 1'b0;
        done = 1'b0; fc2_logit = '0; r_ready = 1'b0;
        for (int k = 0; k < N; k++)     m_in[k]  = '0;
        for (int k = 0; k < M * N; k++) m_fc1[k] = '0;
        for (int k = 0; k < M; k++)     m_fc2[k] = '0;

        repeat (2) @(negedge clk);
        check("rst_s_ready", {63'b0, s_ready}, 64'd0);
        check("rst_busy",    {63'b0, busy},    64'd0);
        check("rst_err",     {63'b0, err},     64'd0);
        check("rst_r_valid", {63'b0, r_valid}, 64'd0);
        check("rst_r_logit", 64'(r_logit),     64'd0);
        check("rst_pulses",  {60'b0, in_vec_wr, fc1_w_wr_all, fc2_w_wr_all, start}, 64'd0);
        check_stage("rst");
        @(posedge clk); #2 rst = 1'b0;
        #1 check("rel_s_ready", {63'b0, s_ready}, 64'd1);

        // fc2 load with fixed bytes {3, -2}
        pkt[0] = 8'd3; pkt[1] = 8'hFE;
        run_pkt(2'b10, 2);
        check("fc2_fixed", 64'(fc2_w_array), 64'h0000_0000_0000_FE03);

        // inference
        pkt[0] = 8'd1; pkt[1] = 8'd2; pkt[2] = 8'd3; pkt[3] = 8'd4;
        run_pkt(2'b00, 4);
        do_infer(6, 24'd1234);

        // stray done in IDLE is ignored
        @(posedge clk); #1 done = 1'b1; fc2_logit = 24'd77;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        check("stray_r_valid", {63'b0, r_valid}, 64'd0);
        check("stray_r_logit", 64'(r_logit), 64'd1234);

        // early last, overlong, reserved, full fc1 load
        fill_rand(2);  run_pkt(2'b00, 2);
        fill_rand(5);  run_pkt(2'b10, 5);
        fill_rand(3);  run_pkt(2'b11, 3);
        fill_rand(8);  run_pkt(2'b01, 8);

        for (int it = 0; it < 8; it++) begin
            kind_r = $urandom_range(0, 3);
            n_r    = $urandom_range(1, 10);
            if (kind_r == 0 && n_r == N) n_r = N - 1;
            fill_rand(n_r);
            run_pkt(2'(kind_r), n_r);
        end

        // second inference with random logit
        fill_rand(4); run_pkt(2'b00, 4);
        logit2 = 24'($urandom) | 24'h80_0000;
        do_infer($urandom_range(1, 10), logit2);

        // inference where done never arrives
        fill_rand(4); run_pkt(2'b00, 4);
        c_rv = n_rv; c_er = n_err;
`ifdef FCN_FEEDER_TIMEOUT_EN
        for (int w = 0; w < 100 && n_err == c_er; w++) @(negedge clk);
        @(negedge clk);
        check("tmo_err_cnt",  n_err - c_er, 1);
        check("tmo_err_time", t_err, t_start + 17);
        check("tmo_no_rvalid", n_rv - c_rv, 0);
        check("tmo_r_logit",  64'(r_logit), 64'(logit2));
        check("tmo_s_ready",  {63'b0, s_ready}, 64'd1);
        @(posedge clk); #1 done = 1'b1; fc2_logit = 24'd5;
        @(posedge clk); #1 done = 1'b0;
        @(negedge clk);
        check("tmo_stray_r_valid", {63'b0, r_valid}, 64'd0);
`else
        repeat (1000) @(negedge clk);
        check("nowd_busy",    {63'b0, busy},    64'd1);
        check("nowd_r_valid", {63'b0, r_valid}, 64'd0);
        check("nowd_s_ready", {63'b0, s_ready}, 64'd0);
        check("nowd_err_cnt", n_err - c_er, 0);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < N; k++)     m_in[k]  = '0;
        for (int k = 0; k < M * N; k++) m_fc1[k] = '0;
        for (int k = 0; k < M; k++)     m_fc2[k] = '0;
`endif

        // reset in the middle of a fc1 load
        fill_rand(6);
        send_pkt(2'b01, 6, 1'b0);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++)     m_in[k]  = '0;
        for (int k = 0; k < M * N; k++) m_fc1[k] = '0;
        for (int k = 0; k < M; k++)     m_fc2[k] = '0;
        check("mid_rst_s_ready", {63'b0, s_ready}, 64'd0);
        check("mid_rst_busy",    {63'b0, busy},    64'd0);
        check("mid_rst_err",     {63'b0, err},     64'd0);
        check("mid_rst_r_logit", 64'(r_logit),     64'd0);
        check("mid_rst_pulses",  {60'b0, in_vec_wr, fc1_w_wr_all, fc2_w_wr_all, start}, 64'd0);
        check_stage("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rel_s_ready", {63'b0, s_ready}, 64'd1);
        fill_rand(2);
        run_pkt(2'b10, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
